spi_reg_ctrl: RTL and testbench
===============================

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 7, register address width; command byte = {rw, addr[6:0]}.
REQ-002 SHALL have parameter DATA_W, default 8, register data width and SPI data byte length.
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port nrst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port spi_reset  input  1  one-cycle strobe on ncs falling edge (frame start), from spi_sync.
REQ-006 SHALL have port spi_read  input  1  one-cycle strobe on sck rising edge while ncs low; sample point.
REQ-007 SHALL have port spi_write  input  1  one-cycle strobe on sck falling edge while ncs low; shift-out point.
REQ-008 SHALL have port mosi_in  input  1  synchronized MOSI, valid when spi_read is high.
REQ-009 SHALL have port miso  output  1  registered serial read data, MSB first.
REQ-010 SHALL have port miso_oe  output  1  high only during the data phase of a read frame.
REQ-011 SHALL have port reg_addr  output  ADDR_W  register address.
REQ-012 SHALL have port reg_wdata  output  DATA_W  write data, valid with reg_we.
REQ-013 SHALL have port reg_we  output  1  one-cycle write strobe.
REQ-014 SHALL have port reg_re  output  1  one-cycle read strobe.
REQ-015 SHALL have port reg_rdata  input  DATA_W  read data, valid exactly one clk after reg_re.
REQ-016 SHALL have port frame_active  output  1  high from spi_reset until the next reset event; low in IDLE.

Function
REQ-017 SHALL implement states IDLE, CMD, DATA; spi_reset in any state -> CMD with bit_cnt=0 and shift register cleared.
REQ-018 In CMD/DATA, SHALL shift mosi_in into an 8-bit rx register LSB-in on each spi_read and increment a 3-bit bit_cnt, which wraps 7->0.
REQ-019 On the 8th spi_read in CMD, SHALL latch rw=rx[7] and reg_addr=rx[6:0] and enter DATA.
REQ-020 On that same edge, if rw=1, SHALL pulse reg_re for one cycle with the new reg_addr, then load tx register from reg_rdata on the following cycle.
REQ-021 On each spi_write in DATA with rw=1, SHALL set miso<=tx[7] and shift tx left by one; miso SHALL hold between strobes.
REQ-022 On the 8th spi_read in DATA with rw=0, SHALL present reg_wdata=rx and pulse reg_we for one cycle at the current reg_addr, then increment reg_addr.
REQ-023 On the 8th spi_read in DATA with rw=1, SHALL increment reg_addr and pulse reg_re on the next cycle, prefetching the next byte for burst reads.
REQ-024 reg_addr increment SHALL wrap modulo 2^ADDR_W (7F->00).
REQ-025 A partial byte (spi_reset before the 8th bit) SHALL produce no reg_we and SHALL be discarded.
REQ-026 reg_we and reg_re SHALL never be high in the same cycle; spi_read/spi_write in IDLE SHALL be ignored.
REQ-027 spi_reset SHALL take priority over a coincident spi_read or spi_write.
REQ-028 Timing SHALL rely on F_SCK <= F_CLK/10: tx load completes before the next spi_write.

Reset
REQ-029 On nrst low, SHALL force state=IDLE, bit_cnt=0, rx=0, tx=0, rw=0, miso=0, miso_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, frame_active=0, effective immediately and asynchronously.
REQ-030 After nrst release, SHALL remain in IDLE until the first spi_reset.

Structure
REQ-031 Package spi_reg_pkg SHALL hold the state enum, CMD_RW_BIT=7 and default ADDR_W/DATA_W constants.
REQ-032 SHALL be a single flat module with no sub-module; spi_sync is instantiated by the parent, outside this block.

Verification
REQ-033 Write frame 0x05,0xA5 -> exactly one reg_we with reg_addr=05, reg_wdata=A5; reg_re never asserted.
REQ-034 Read frame 0x83 with reg 03=0x3C -> reg_re at addr 03; miso bits during data byte = 0,0,1,1,1,1,0,0; miso_oe high.
REQ-035 Burst write 0x7F,0x11,0x22 -> reg_we at 7F with data 11, then at 00 with data 22 (address wrap).
REQ-036 Burst read 0x90,x,x with regs 10=0xAA, 11=0x55 -> miso outputs AA then 55; reg_re at 10, then at 11, then at 12.
REQ-037 Write frame aborted by spi_reset after 5 data bits, then write frame 0x02,0x0F -> no reg_we for the aborted byte; one reg_we at 02 with data 0F.
REQ-038 nrst asserted mid-read frame -> all outputs 0 in the same cycle; spi_read strobes are ignored until the next spi_reset.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-access controller.
package spi_reg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

    localparam int CMD_RW_BIT = 7;
    localparam int BYTE_W     = 8;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/spi_reg_ctrl.sv
// SPI slave frame decoder: command byte {rw, addr} followed by auto-incrementing
// burst data bytes, translated into single-cycle register read/write strobes.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              spi_reset,
    input  logic              spi_read,
    input  logic              spi_write,
    input  logic              mosi_in,
    output logic              miso,
    output logic              miso_oe,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              frame_active
);

    state_e              state_q, state_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BYTE_W-1:0]   rx_q, rx_d;
    logic [BYTE_W-1:0]   rx_shift;
    logic [DATA_W-1:0]   tx_q, tx_d;
    logic                rw_q, rw_d;
    logic                miso_q, miso_d;
    logic                oe_q, oe_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                load_q, load_d;
    logic                active_q, active_d;

    assign rx_shift = (rx_q << 1) | BYTE_W'(mosi_in);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        miso_d    = miso_q;
        oe_d      = oe_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        // reg_rdata arrives one clk after reg_re; catch it one cycle later
        load_d    = re_q;
        active_d  = active_q;

        if (load_q) begin
            tx_d = reg_rdata;
        end
        if (we_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (spi_reset) begin
            state_d   = ST_CMD;
            bit_cnt_d = 3'd0;
            rx_d      = '0;
            oe_d      = 1'b0;
            active_d  = 1'b1;
        end else if (state_q != ST_IDLE) begin
            if (spi_read) begin
                rx_d      = rx_shift;
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    if (state_q == ST_CMD) begin
                        state_d = ST_DATA;
                        rw_d    = rx_shift[CMD_RW_BIT];
                        addr_d  = ADDR_W'(rx_shift[CMD_RW_BIT-1:0]);
                        oe_d    = rx_shift[CMD_RW_BIT];
                        re_d    = rx_shift[CMD_RW_BIT];
                    end else if (rw_q) begin
                        // prefetch the next byte of a burst read
                        addr_d = addr_q + ADDR_W'(1);
                        re_d   = 1'b1;
                    end else begin
                        wdata_d = DATA_W'(rx_shift);
                        we_d    = 1'b1;
                    end
                end
            end
            if (spi_write && (state_q == ST_DATA) && rw_q) begin
                miso_d = tx_q[DATA_W-1];
                tx_d   = tx_q << 1;
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            rx_q      <= '0;
            tx_q      <= '0;
            rw_q      <= 1'b0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            load_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            miso_q    <= miso_d;
            oe_q      <= oe_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
            load_q    <= load_d;
            active_q  <= active_d;
        end
    end

    assign miso         = miso_q;
    assign miso_oe      = oe_q;
    assign reg_addr     = addr_q;
    assign reg_wdata    = wdata_q;
    assign reg_we       = we_q;
    assign reg_re       = re_q;
    assign frame_active = active_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: register strobes and MISO bytes are
// queued as frames are driven and checked as the DUT produces them.
module tb_spi_reg_ctrl;

    logic       clk = 1'b0;
    logic       nrst;
    logic       spi_reset;
    logic       spi_read;
    logic       spi_write;
    logic       mosi_in;
    logic       miso;
    logic       miso_oe;
    logic [6:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata;
    logic       frame_active;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        exp_we_q[$];
    logic [6:0] exp_re_q[$];
    logic [7:0] exp_miso_q[$];
    logic [7:0] mem [128];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    spi_reg_ctrl #(.ADDR_W(7), .DATA_W(8)) dut (
        .clk          (clk),
        .nrst         (nrst),
        .spi_reset    (spi_reset),
        .spi_read     (spi_read),
        .spi_write    (spi_write),
        .mosi_in      (mosi_in),
        .miso         (miso),
        .miso_oe      (miso_oe),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_we       (reg_we),
        .reg_re       (reg_re),
        .reg_rdata    (reg_rdata),
        .frame_active (frame_active)
    );

    // Register file model: data is valid only in the cycle after reg_re.
    always @(posedge clk) begin
        reg_rdata <= reg_re ? mem[reg_addr] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reg_we || reg_re) begin
            check("we_re_exclusive", 32'(reg_we & reg_re), 32'(0));
        end
        if (reg_we) begin
            if (exp_we_q.size() == 0) begin
                check("we_unexpected", 32'(reg_we), 32'(0));
            end else begin
                wr_t e;
                e = exp_we_q.pop_front();
                check("we_addr", 32'(reg_addr), 32'(e.addr));
                check("we_data", 32'(reg_wdata), 32'(e.data));
            end
        end
        if (reg_re) begin
            if (exp_re_q.size() == 0) begin
                check("re_unexpected", 32'(reg_re), 32'(0));
            end else begin
                logic [6:0] a;
                a = exp_re_q.pop_front();
                check("re_addr", 32'(reg_addr), 32'(a));
            end
        end
    end

    task automatic gap(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic frame_start();
        @(negedge clk) spi_reset = 1'b1;
        @(negedge clk) spi_reset = 1'b0;
        gap(4);
    endtask

    // Master side: sample MISO on the rising-edge strobe, shift on the falling one.
    task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            mosi_in = mo[i];
            gap(4);
            @(negedge clk);
            spi_read = 1'b1;
            mi[i] = miso;
            @(negedge clk);
            spi_read = 1'b0;
            gap(4);
            @(negedge clk);
            spi_write = 1'b1;
            @(negedge clk);
            spi_write = 1'b0;
        end
    endtask

    task automatic read_byte_check(input string tag);
        logic [7:0] mi;
        logic [7:0] e;
        spi_bits(8'h00, 8, mi);
        if (exp_miso_q.size() == 0) begin
            check({tag, "_nothing_queued"}, 32'(mi), 32'hFFFF_FFFF);
        end else begin
            e = exp_miso_q.pop_front();
            check(tag, 32'(mi), 32'(e));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] dummy;
        foreach (mem[i]) mem[i] = 8'(i) ^ 8'h5A;
        mem[7'h03] = 8'h3C;
        mem[7'h10] = 8'hAA;
        mem[7'h11] = 8'h55;

        nrst = 1'b0;
        spi_reset = 1'b0;
        spi_read = 1'b0;
        spi_write = 1'b0;
        mosi_in = 1'b0;
        gap(3);
        check("rst_miso", 32'(miso), 32'(0));
        check("rst_oe", 32'(miso_oe), 32'(0));
        check("rst_addr", 32'(reg_addr), 32'(0));
        check("rst_wdata", 32'(reg_wdata), 32'(0));
        check("rst_strobes", 32'({reg_we, reg_re}), 32'(0));
        check("rst_active", 32'(frame_active), 32'(0));
        nrst = 1'b1;
        gap(3);
        check("idle_active", 32'(frame_active), 32'(0));

        // single write 0x05 <- 0xA5
        exp_we_q.push_back('{addr: 7'h05, data: 8'hA5});
        frame_start();
        check("active_after_reset", 32'(frame_active), 32'(1));
        spi_bits(8'h05, 8, dummy);
        spi_bits(8'hA5, 8, dummy);
        check("write_oe", 32'(miso_oe), 32'(0));
        gap(5);

        // single read of reg 03 (prefetch of 04 follows the data byte)
        exp_re_q.push_back(7'h03);
        exp_re_q.push_back(7'h04);
        exp_miso_q.push_back(8'h3C);
        frame_start();
        spi_bits(8'h83, 8, dummy);
        check("read_oe", 32'(miso_oe), 32'(1));
        read_byte_check("read_miso");
        gap(5);

        // burst write with address wrap 7F -> 00
        exp_we_q.push_back('{addr: 7'h7F, data: 8'h11});
        exp_we_q.push_back('{addr: 7'h00, data: 8'h22});
        frame_start();
        spi_bits(8'h7F, 8, dummy);
        spi_bits(8'h11, 8, dummy);
        spi_bits(8'h22, 8, dummy);
        gap(5);
        check("wrap_addr", 32'(reg_addr), 32'(7'h01));

        // burst read 10, 11 with prefetch of 12
        exp_re_q.push_back(7'h10);
        exp_re_q.push_back(7'h11);
        exp_re_q.push_back(7'h12);
        exp_miso_q.push_back(8'hAA);
        exp_miso_q.push_back(8'h55);
        frame_start();
        spi_bits(8'h90, 8, dummy);
        read_byte_check("burst_miso0");
        read_byte_check("burst_miso1");
        gap(5);

        // aborted partial byte, then a clean write
        exp_we_q.push_back('{addr: 7'h02, data: 8'h0F});
        frame_start();
        spi_bits(8'h01, 8, dummy);
        spi_bits(8'hC3, 5, dummy);
        frame_start();
        spi_bits(8'h02, 8, dummy);
        spi_bits(8'h0F, 8, dummy);
        gap(5);

        // asynchronous reset in the middle of a read data byte
        exp_re_q.push_back(7'h10);
        frame_start();
        spi_bits(8'h90, 8, dummy);
        spi_bits(8'h00, 2, dummy);
        check("pre_rst_miso", 32'(miso), 32'(1));
        check("pre_rst_oe", 32'(miso_oe), 32'(1));
        @(negedge clk);
        #2 nrst = 1'b0;
        #1;
        check("async_miso", 32'(miso), 32'(0));
        check("async_oe", 32'(miso_oe), 32'(0));
        check("async_addr", 32'(reg_addr), 32'(0));
        check("async_active", 32'(frame_active), 32'(0));
        gap(2);
        nrst = 1'b1;
        gap(2);
        // strobes without a frame start must be ignored
        spi_bits(8'h86, 8, dummy);
        check("ignored_active", 32'(frame_active), 32'(0));
        check("ignored_oe", 32'(miso_oe), 32'(0));
        exp_we_q.push_back('{addr: 7'h06, data: 8'h77});
        frame_start();
        spi_bits(8'h06, 8, dummy);
        spi_bits(8'h77, 8, dummy);
        gap(5);

        check("we_left", 32'(exp_we_q.size()), 32'(0));
        check("re_left", 32'(exp_re_q.size()), 32'(0));
        check("miso_left", 32'(exp_miso_q.size()), 32'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
